apb_req_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the APB master datapath (`APB_topmodule`). It latches a command from one of two requesters and drives the `transfer`, `read_write`, `apb_read_paddr`, `apb_write_paddr` and `apb_write_data` inputs. It then waits for `pready`, returns read data with a one-cycle completion pulse, and alternates priority between the requesters. A watchdog aborts any transfer that never sees `pready`.

---
 rtl/apb_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter : two-requester round-robin arbiter/sequencer for an APB master
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_req_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  m0_req,
  input  logic                  m0_rw,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_done,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_rw,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  transfer,
  output logic                  read_write,
  output logic [ADDR_WIDTH-1:0] apb_read_paddr,
  output logic [ADDR_WIDTH-1:0] apb_write_paddr,
  output logic [DATA_WIDTH-1:0] apb_write_data,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  gnt_id_q, gnt_id_d;
  logic                  cmd_rw_q, cmd_rw_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic                  w_gnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      gnt_id_q    <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    done_d      = 2'b00;
    err_d       = 2'b00;
    // A lone m1 request selects 1, a lone m0 request selects 0.
    w_gnt       = (m0_req && m1_req) ? rr_ptr_q : m1_req;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          gnt_id_d    = w_gnt;
          cmd_rw_d    = w_gnt ? m1_rw    : m0_rw;
          cmd_addr_d  = w_gnt ? m1_addr  : m0_addr;
          cmd_wdata_d = w_gnt ? m1_wdata : m0_wdata;
          cnt_d       = '0;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // pready in the last allowed cycle wins over the watchdog.
        if (pready) begin
          if (!cmd_rw_q) begin
            rdata_d = prdata;
          end
          done_d[gnt_id_q] = 1'b1;
          state_d          = S_COMPLETE;
        end else if (cnt_q == C_CNT_LAST) begin
          done_d[gnt_id_q] = 1'b1;
          err_d[gnt_id_q]  = 1'b1;
          state_d          = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        rr_ptr_d = ~gnt_id_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign transfer        = (state_q == S_ACCESS);
  assign busy            = (state_q != S_IDLE);
  assign read_write      = cmd_rw_q;
  assign apb_read_paddr  = cmd_addr_q;
  assign apb_write_paddr = cmd_addr_q;
  assign apb_write_data  = cmd_wdata_q;
  assign rdata           = rdata_q;
  assign m0_done         = done_q[0];
  assign m1_done         = done_q[1];
  assign m0_err          = err_q[0];
  assign m1_err          = err_q[1];

endmodule

`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter : directed + randomized bench with a transaction-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_req_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          presetn;
  logic [1:0]    req;
  logic [1:0]    rw;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] prdata;
  logic          pready;

  wire           m0_done, m0_err, m1_done, m1_err;
  wire [DW-1:0]  rdata;
  wire           busy, transfer, read_write;
  wire [AW-1:0]  apb_read_paddr, apb_write_paddr;
  wire [DW-1:0]  apb_write_data;

  int            n_total = 0;
  int            n_pass  = 0;

  // transaction-level model state
  logic [DW-1:0] m_rdata;
  int            m_rr;
  bit            pending [2];
  bit            cool    [2];

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .m0_req          (req[0]),
    .m0_rw           (rw[0]),
    .m0_addr         (addr[0]),
    .m0_wdata        (wdata[0]),
    .m0_done         (m0_done),
    .m0_err          (m0_err),
    .m1_req          (req[1]),
    .m1_rw           (rw[1]),
    .m1_addr         (addr[1]),
    .m1_wdata        (wdata[1]),
    .m1_done         (m1_done),
    .m1_err          (m1_err),
    .rdata           (rdata),
    .busy            (busy),
    .transfer        (transfer),
    .read_write      (read_write),
    .apb_read_paddr  (apb_read_paddr),
    .apb_write_paddr (apb_write_paddr),
    .apb_write_data  (apb_write_data),
    .prdata          (prdata),
    .pready          (pready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic raise(input int i, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rw[i]      = r;
    addr[i]    = a;
    wdata[i]   = d;
    req[i]     = 1'b1;
    pending[i] = 1'b1;
  endtask

  function automatic int exp_grant();
    if (pending[0] && pending[1]) return m_rr;
    return pending[1] ? 1 : 0;
  endfunction

  // One full transaction for requester g. d = ACCESS cycle on which pready
  // is raised (0 = never); refill re-raises the other requester mid-ACCESS.
  task automatic run_txn(input int g, input int d, input logic [DW-1:0] pd, input bit refill);
    bit          ok;
    logic [1:0]  exp_done;
    tick();
    if (refill) begin
      for (int i = 0; i < 2; i++)
        if (!pending[i] && i != g) raise(i, 1'($urandom), AW'($urandom), DW'($urandom));
    end
    for (int k = 1; k <= TO; k++) begin
      check("acc_xfer", transfer, 1);
      check("acc_busy", busy, 1);
      check("acc_rw", read_write, rw[g]);
      check("acc_raddr", apb_read_paddr, addr[g]);
      check("acc_waddr", apb_write_paddr, addr[g]);
      check("acc_wdata", apb_write_data, wdata[g]);
      check("acc_done", {m1_done, m0_done}, 0);
      pready = (k == d);
      prdata = (k == d) ? pd : DW'($urandom);
      tick();
      if (k == d) break;
    end
    pready = 1'b0;
    ok = (d >= 1 && d <= TO);
    if (ok && !rw[g]) m_rdata = pd;
    exp_done = 2'b01 << g;
    check("cmp_done", {m1_done, m0_done}, exp_done);
    check("cmp_err", {m1_err, m0_err}, ok ? 2'b00 : exp_done);
    check("cmp_xfer", transfer, 0);
    check("cmp_busy", busy, 1);
    check("cmp_rdata", rdata, m_rdata);
    check("cmp_hold_addr", apb_read_paddr, addr[g]);
    req[g]     = 1'b0;
    pending[g] = 1'b0;
    cool[g]    = 1'b1;
    m_rr       = 1 - g;
    tick();
  endtask

  initial begin
    presetn = 1'b0;
    req     = 2'b00;
    rw      = 2'b00;
    pready  = 1'b0;
    prdata  = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i]    = '0;
      wdata[i]   = '0;
      pending[i] = 1'b0;
      cool[i]    = 1'b0;
    end
    m_rdata = '0;
    m_rr    = 0;

    tick();
    tick();
    check("rst_xfer", transfer, 0);
    check("rst_busy", busy, 0);
    check("rst_done", {m1_done, m0_done, m1_err, m0_err}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_apb", {read_write, apb_read_paddr, apb_write_paddr, apb_write_data}, 0);
    presetn = 1'b1;
    tick();

    // m0 write, pready on 2nd ACCESS cycle
    raise(0, 1'b1, 8'h10, 8'hA5);
    run_txn(0, 2, 8'h00, 1'b0);

    // m1 read returning 0x5A, then held for 5 idle cycles
    raise(1, 1'b0, 8'h10, 8'h00);
    run_txn(1, 1, 8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("hold_rdata", rdata, 8'h5A);
    check("hold_rw", read_write, 0);
    check("hold_busy", busy, 0);

    // m0 read timeout, then pready on the final allowed cycle
    raise(0, 1'b0, 8'h44, 8'h00);
    run_txn(0, 0, 8'h00, 1'b0);
    tick();
    raise(0, 1'b0, 8'h45, 8'h00);
    run_txn(0, TO, 8'hC3, 1'b0);

    // reset during ACCESS
    m_rr = 1;
    raise(1, 1'b1, 8'h33, 8'h77);
    tick();
    tick();
    #2 presetn = 1'b0;
    #1;
    check("arst_xfer", transfer, 0);
    check("arst_busy", busy, 0);
    check("arst_done", {m1_done, m0_done, m1_err, m0_err}, 0);
    check("arst_apb", {read_write, apb_read_paddr, apb_write_paddr, apb_write_data}, 0);
    check("arst_rdata", rdata, 0);
    req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      pending[i] = 1'b0;
      cool[i]    = 1'b0;
    end
    m_rdata = '0;
    m_rr    = 0;
    tick();
    check("arst_nodone", {m1_done, m0_done}, 0);
    presetn = 1'b1;
    tick();

    // both requesting continuously: m0, m1, m0, m1
    raise(0, 1'b0, 8'h01, 8'h00);
    raise(1, 1'b1, 8'h02, 8'h22);
    for (int t = 0; t < 4; t++) begin
      check("rr_order", exp_grant(), t % 2);
      run_txn(exp_grant(), $urandom_range(1, 4), DW'($urandom), 1'b1);
      cool[0] = 1'b0;
      cool[1] = 1'b0;
    end
    req = 2'b00;
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    tick();

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      check("idle_busy", busy, 0);
      check("idle_xfer", transfer, 0);
      check("idle_done", {m1_done, m0_done}, 0);
      for (int i = 0; i < 2; i++)
        if (!pending[i] && !cool[i] && $urandom_range(0, 2) != 0)
          raise(i, 1'($urandom), AW'($urandom), DW'($urandom));
      cool[0] = 1'b0;
      cool[1] = 1'b0;
      if (!pending[0] && !pending[1]) begin
        tick();
        continue;
      end
      run_txn(exp_grant(), $urandom_range(0, TO), DW'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
